// File: rtl/match_event_fifo.sv
// rtl/match_event_fifo.sv - rising-edge match capture FIFO with saturating total and sticky overflow
// Pushes Count on each Boolean rising edge; drains over a valid/ready port.
module match_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic [WIDTH-1:0]           Count,
  input  logic                       Boolean,
  input  logic                       Clear_Ovf,
  input  logic                       Out_Ready,
  output logic                       Out_Valid,
  output logic [WIDTH-1:0]           Out_Data,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Overflow,
  output logic [CNT_W-1:0]           Match_Total
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic             bool_q, bool_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic empty, full, match_event, pop, push, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign match_event = Boolean & ~bool_q;
  assign pop         = ~empty & Out_Ready;
  assign push        = match_event & (~full | pop);
  assign drop        = match_event & full & ~pop;

  always_comb begin
    bool_d   = Boolean;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    total_d  = total_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = Count;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Clear_Ovf) begin
      ovf_d = 1'b0;
    end
    if (match_event && (total_q != {CNT_W{1'b1}})) begin
      total_d = total_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bool_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      bool_q   <= bool_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      total_q  <= total_d;
    end
  end

  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign Out_Valid   = ~empty;
  assign Out_Data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign Level       = wr_ptr_q - rd_ptr_q;
  assign Overflow    = ovf_q;
  assign Match_Total = total_q;

endmodule

// File: tb/tb_match_event_fifo.sv
// tb/tb_match_event_fifo.sv - randomized and directed check of match_event_fifo against a queue model
module tb_match_event_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             Clock = 1'b0;
  logic             Reset_n = 1'b0;
  logic [WIDTH-1:0] Count = '0;
  logic             Boolean = 1'b0;
  logic             Clear_Ovf = 1'b0;
  logic             Out_Ready = 1'b0;
  logic             Out_Valid, Out_Valid3;
  logic [WIDTH-1:0] Out_Data, Out_Data3;
  logic [3:0]       Level, Level3;
  logic             Overflow, Overflow3;
  logic [7:0]       Match_Total;
  logic [2:0]       Match_Total3;

  match_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Count(Count), .Boolean(Boolean),
    .Clear_Ovf(Clear_Ovf), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid),
    .Out_Data(Out_Data), .Level(Level), .Overflow(Overflow), .Match_Total(Match_Total)
  );

  match_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(3)) dut_sat (
    .Clock(Clock), .Reset_n(Reset_n), .Count(Count), .Boolean(Boolean),
    .Clear_Ovf(Clear_Ovf), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid3),
    .Out_Data(Out_Data3), .Level(Level3), .Overflow(Overflow3), .Match_Total(Match_Total3)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  // Reference state: queue of captured counts, previous Boolean, totals, overflow.
  int m_q[$];
  bit m_prev;
  int m_total;
  int m_total3;
  bit m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_data;
    exp_data = (m_q.size() != 0) ? m_q[0] : 0;
    check({tag, ".valid"}, int'(Out_Valid), (m_q.size() != 0) ? 1 : 0);
    check({tag, ".level"}, int'(Level), m_q.size());
    check({tag, ".data"}, int'(Out_Data), exp_data);
    check({tag, ".ovf"}, int'(Overflow), int'(m_ovf));
    check({tag, ".total"}, int'(Match_Total), m_total);
    check({tag, ".total3"}, int'(Match_Total3), m_total3);
    check({tag, ".level3"}, int'(Level3), m_q.size());
    check({tag, ".data3"}, int'(Out_Data3), exp_data);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_prev = 0;
    m_total = 0;
    m_total3 = 0;
    m_ovf = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the spec rules, then compare.
  task automatic step(input bit b, input int c, input bit rdy, input bit clr, input string tag);
    bit ev;
    Boolean = b;
    Count = c[WIDTH-1:0];
    Out_Ready = rdy;
    Clear_Ovf = clr;
    ev = b && !m_prev;
    m_prev = b;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (ev) begin
      if (m_total < 255) m_total++;
      if (m_total3 < 7) m_total3++;
      if (m_q.size() < DEPTH) m_q.push_back(c & 15);
      else m_ovf = 1;
    end
    if (clr && !(ev && m_q.size() == DEPTH && !(rdy && m_q.size() != 0) && m_ovf)) begin
      m_ovf = m_ovf;
    end
    @(posedge Clock);
    #1;
    compare_all(tag);
  endtask

  // Clear applies only when no drop happened this cycle; handled here to keep step readable.
  task automatic step_clr(input bit b, input int c, input bit rdy, input string tag);
    bit dropping;
    dropping = b && !m_prev && m_q.size() == DEPTH && !rdy;
    if (!dropping) m_ovf = 0;
    step(b, c, rdy, 1'b1, tag);
  endtask

  task automatic async_reset(input string tag);
    Boolean = 1'b1;
    Out_Ready = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    model_clear();
    compare_all(tag);
    @(posedge Clock);
    #1;
    compare_all({tag, ".held"});
    Reset_n = 1'b1;
    Boolean = 1'b0;
    Out_Ready = 1'b0;
  endtask

  initial begin
    model_clear();
    #1;
    compare_all("por");
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    async_reset("reset1");

    // Counter sweep with Boolean high at 7, 8, 10..15.
    for (int c = 0; c < 16; c++) step((c == 7 || c == 8 || c >= 10), c, 1'b0, 1'b0, "sweep");
    check("sweep.level", int'(Level), 2);
    check("sweep.head", int'(Out_Data), 7);
    step(1'b0, 0, 1'b1, 1'b0, "sweep.pop1");
    check("sweep.second", int'(Out_Data), 10);
    step(1'b0, 0, 1'b1, 1'b0, "sweep.pop2");

    // Level-held Boolean yields one push.
    async_reset("reset2");
    for (int i = 0; i < 5; i++) step(1'b1, 3, 1'b0, 1'b0, "hold");
    check("hold.total", int'(Match_Total), 1);
    step(1'b0, 0, 1'b0, 1'b0, "hold.low");

    // Fill past depth, then clear overflow.
    async_reset("reset3");
    for (int i = 0; i < 9; i++) begin
      step(1'b1, i + 1, 1'b0, 1'b0, "fill.hi");
      step(1'b0, 0, 1'b0, 1'b0, "fill.lo");
    end
    check("fill.ovf", int'(Overflow), 1);
    check("fill.total", int'(Match_Total), 9);
    step_clr(1'b0, 0, 1'b0, "fill.clr");

    // Full FIFO with simultaneous push and pop.
    step(1'b1, 12, 1'b1, 1'b0, "fullpp");
    check("fullpp.level", int'(Level), 8);
    check("fullpp.ovf", int'(Overflow), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0, "drain");

    // Saturation of the narrow counter plus mid-stream reset with 3 queued.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i, 1'b0, 1'b0, "sat.hi");
      step(1'b0, 0, i >= 5, 1'b0, "sat.lo");
    end
    check("sat.total3", int'(Match_Total3), 7);
    async_reset("reset4");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i + 4, 1'b0, 1'b0, "pre.hi");
      step(1'b0, 0, 1'b0, 1'b0, "pre.lo");
    end
    check("pre.level", int'(Level), 3);
    async_reset("reset5");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit b, r;
      int c;
      b = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 15);
      if ($urandom_range(0, 40) == 0) step_clr(b, c, r, "rand.clr");
      else step(b, c, r, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
